// File: rtl/demux4_buf_pkg.sv
// Shared datapath definitions for the 1-to-4 demux and the selector muxes.
// Holds the default data width, channel count and selector encodings.
package demux4_buf_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NCH       = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t CH0 = 2'b00;
    localparam sel_t CH1 = 2'b01;
    localparam sel_t CH2 = 2'b10;
    localparam sel_t CH3 = 2'b11;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO for one demux channel; head entry is always on dout.
// Ports: clk, rst, push/din in, pop in, full/empty/dout out.
module demux_fifo2
    import demux4_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [2];
    logic             wptr;
    logic             rptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign dout    = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (do_push) wptr <= ~wptr;
            if (do_pop)  rptr <= ~rptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/demux4_buf.sv
// 1-to-4 buffered demux: routes in_data to channel in_sel, 2-deep FIFO each.
// Ports: clk, rst, in_data/in_sel/in_valid/in_ready, out_data/out_valid/out_ready, busy.
module demux4_buf
    import demux4_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               busy
);

    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [WIDTH-1:0] head [NCH];
    logic             xfer;

    // Ready looks only at the selected channel's registered fullness,
    // so a pop in the same cycle does not open the input.
    assign in_ready = ~full[in_sel];
    assign xfer     = in_valid & in_ready;

    always_comb begin
        push = '0;
        unique case (in_sel)
            CH0: push[0] = xfer;
            CH1: push[1] = xfer;
            CH2: push[2] = xfer;
            CH3: push[3] = xfer;
        endcase
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign pop[k] = out_ready[k] & ~empty[k];

        demux_fifo2 #(.WIDTH(WIDTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .din   (in_data),
            .pop   (pop[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .dout  (head[k])
        );

        assign out_data[k*WIDTH +: WIDTH] = head[k];
    end

    assign out_valid = ~empty;
    assign busy      = |out_valid;

endmodule
